// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit mod-(limit+1) counter with start/stop/pause, one-shot and periodic modes.
// Optional tick prescaler is enabled by defining PRESCALER_EN (adds the presc_div port).
module count_seq_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
`ifdef PRESCALER_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} st_t;

  st_t              st_q, st_d;
  logic [WIDTH-1:0] count_q, count_d, limit_q;
  logic             mode_q, tc_q, tc_d, done_q, done_d, busy_q, busy_d;
  logic             ld, tick;

`ifdef PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_div_q;

  // Prescaler only advances in RUN without pause/stop; it holds while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      presc_div_q <= '0;
    end else if (ld) begin
      presc_q     <= '0;
      presc_div_q <= presc_div;
    end else if ((st_q == RUN || st_q == PAUSE) && stop) begin
      presc_q <= '0;
    end else if (st_q == RUN && !pause) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  assign tick = (presc_q == presc_div_q);
`else
  // Without a prescaler every RUN cycle is a tick.
  assign tick = (PRESC_W > 0);
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      limit_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      if (ld) begin
        limit_q <= limit;
        mode_q  <= mode;
      end
    end
  end

  // Next state: stop > pause > tick
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:  if (start && limit != '0) st_d = RUN;
      RUN: begin
        if (stop)                                        st_d = IDLE;
        else if (pause)                                  st_d = PAUSE;
        else if (tick && count_q == limit_q && !mode_q)  st_d = DONE;
      end
      PAUSE: begin
        if (stop)        st_d = IDLE;
        else if (!pause) st_d = RUN;
      end
      DONE:  st_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = 1'b0;
    ld      = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          ld      = 1'b1;
          count_d = '0;
          done_d  = (limit == '0);
        end
      end
      RUN: begin
        if (stop) begin
          count_d = '0;
        end else if (!pause && tick) begin
          if (count_q != limit_q) begin
            count_d = count_q + 1'b1;
          end else begin
            tc_d = 1'b1;
            if (mode_q) count_d = '0;
            else        done_d  = 1'b1;
          end
        end
      end
      PAUSE: if (stop) count_d = '0;
      DONE:  ;
    endcase
    busy_d = (st_d == RUN) || (st_d == PAUSE);
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;
  assign state = st_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: reset, one-shot, periodic, pause, stop, ignored start, zero limit, prescaler.
module tb_count_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, stop, pause, mode;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy, tc, done;
  logic [1:0] state;
`ifdef PRESCALER_EN
  logic [3:0] presc_div;
`endif
  int errors = 0;
  int checks = 0;

  count_seq_ctrl #(.WIDTH(4), .PRESC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .limit(limit),
`ifdef PRESCALER_EN
    .presc_div(presc_div),
`endif
    .count(count), .busy(busy), .tc(tc), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input int st, input int b, input int t, input int d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = 4'd0;
`ifdef PRESCALER_EN
    presc_div = 4'd0;
`endif
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // one-shot, limit 3
    limit = 4'd3; mode = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    chk_all("os.start", 0, 1, 1, 0, 0);
    cyc(); chk("os.c1", 32'(count), 1);
    cyc(); chk("os.c2", 32'(count), 2);
    cyc(); chk_all("os.c3", 3, 1, 1, 0, 0);
    cyc(); chk_all("os.term", 3, 3, 0, 1, 1);
    cyc(); chk_all("os.idle", 3, 0, 0, 0, 0);
    cyc(); chk_all("os.hold", 3, 0, 0, 0, 0);

    // periodic, limit 15: natural wrap
    limit = 4'd15; mode = 1'b1; start = 1'b1;
    cyc(); start = 1'b0;
    chk_all("per.start", 0, 1, 1, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 16; i++) begin
        cyc();
        chk("per.count", 32'(count), 32'(i % 16));
        chk("per.tc", 32'(tc), 32'(i == 16));
        chk("per.busy", 32'(busy), 1);
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    chk_all("per.stop", 0, 0, 0, 0, 0);

    // pause at count 4 for 5 cycles
    limit = 4'd9; mode = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    repeat (4) cyc();
    chk("pz.c4", 32'(count), 4);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk_all("pz.hold", 4, 2, 1, 0, 0);
    end
    pause = 1'b0;
    cyc(); chk_all("pz.resume", 4, 1, 1, 0, 0);
    for (int i = 5; i <= 9; i++) begin
      cyc(); chk("pz.count", 32'(count), 32'(i));
    end
    cyc(); chk_all("pz.term", 9, 3, 0, 1, 1);
    cyc();

    // stop on terminal tick; start while busy ignored
    limit = 4'd6; mode = 1'b0; start = 1'b1;
    cyc();
    limit = 4'd2; mode = 1'b1;
    repeat (6) cyc();
    start = 1'b0;
    chk_all("stp.c6", 6, 1, 1, 0, 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk_all("stp.idle", 0, 0, 0, 0, 0);
    cyc(); chk_all("stp.after", 0, 0, 0, 0, 0);

    // start with limit 0: done pulse, stay idle
    limit = 4'd0; start = 1'b1; cyc(); start = 1'b0;
    chk_all("zero.start", 0, 0, 0, 0, 1);
    cyc(); chk_all("zero.after", 0, 0, 0, 0, 0);

    // async reset mid-run at count 5
    limit = 4'd9; mode = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    repeat (5) cyc();
    chk("rst.c5", 32'(count), 5);
    #2 rst_n = 1'b0;
    #1 chk_all("rst.async", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_all("rst.after", 0, 0, 0, 0, 0);
    end

`ifdef PRESCALER_EN
    // prescaler /3, limit 2 one-shot: done 9 cycles after entering RUN
    presc_div = 4'd2; limit = 4'd2; mode = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    chk_all("pre.start", 0, 1, 1, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("pre.count", 32'(count), (k == 9) ? 32'd2 : 32'(k / 3));
      chk("pre.done", 32'(done), 32'(k == 9));
    end
    cyc(); chk("pre.idle", 32'(state), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
